// File: rtl/hazard_scoreboard_if.sv
// Issue/retire/decode-query bundle between the pipeline control and the hazard scoreboard.
interface hazard_scoreboard_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          issue_valid;
  logic          issue_rd_en;
  logic [4:0]    issue_rd_adr;
  logic          issue_is_load;
  logic          dmem_rsp_valid;
  logic          wb_valid;
  logic          dec_rs1_en;
  logic [4:0]    dec_rs1_adr;
  logic          dec_rs2_en;
  logic [4:0]    dec_rs2_adr;
  logic          stall;
  logic          full;
  logic [CW-1:0] count;
  logic          load_pending;
  logic          protocol_err;

  modport master (
    output issue_valid, issue_rd_en, issue_rd_adr, issue_is_load,
           dmem_rsp_valid, wb_valid,
           dec_rs1_en, dec_rs1_adr, dec_rs2_en, dec_rs2_adr,
    input  stall, full, count, load_pending, protocol_err
  );

  modport slave (
    input  issue_valid, issue_rd_en, issue_rd_adr, issue_is_load,
           dmem_rsp_valid, wb_valid,
           dec_rs1_en, dec_rs1_adr, dec_rs2_en, dec_rs2_adr,
    output stall, full, count, load_pending, protocol_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-order scoreboard of in-flight instructions; flags load-use hazards and capacity
// stalls to decode, and latches any handshake misuse in a sticky error bit.
module hazard_scoreboard #(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  hazard_scoreboard_if.slave sb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_rd_en;
  logic [DEPTH-1:0] r_is_load;
  logic [DEPTH-1:0] r_ready;
  logic [4:0]       r_rd_adr [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_perr;

  logic          w_full;
  logic          w_issue_acc;
  logic          w_retire_acc;
  logic          w_perr_set;
  logic          w_ld_found;
  logic [AW-1:0] w_ld_idx;
  logic [AW-1:0] w_idx;
  logic          w_rs1_chk;
  logic          w_rs2_chk;
  logic          w_haz1;
  logic          w_haz2;

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_issue_acc  = sb.issue_valid && !w_full;
  assign w_retire_acc = sb.wb_valid && (r_count != {CW{1'b0}});
  assign w_rs1_chk    = sb.dec_rs1_en && (sb.dec_rs1_adr != 5'd0);
  assign w_rs2_chk    = sb.dec_rs2_en && (sb.dec_rs2_adr != 5'd0);

  assign w_perr_set = (sb.issue_valid && w_full)
                    || (sb.dmem_rsp_valid && !w_ld_found)
                    || (sb.wb_valid && (r_count == {CW{1'b0}}))
                    || (w_retire_acc && !r_ready[r_head]);

  // Walk from head to tail: the last match seen is the youngest producer, the first
  // outstanding load seen (walking backwards, last assignment) is the oldest.
  always_comb begin
    w_ld_found = 1'b0;
    w_ld_idx   = {AW{1'b0}};
    w_haz1     = 1'b0;
    w_haz2     = 1'b0;
    w_idx      = {AW{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_idx      = r_head + AW'(i);
      w_ld_found = (r_valid[w_idx] && r_is_load[w_idx] && !r_ready[w_idx]) ? 1'b1 : w_ld_found;
      w_ld_idx   = (r_valid[w_idx] && r_is_load[w_idx] && !r_ready[w_idx]) ? w_idx : w_ld_idx;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_idx  = r_head + AW'(i);
      w_haz1 = (w_rs1_chk && r_valid[w_idx] && r_rd_en[w_idx] && (r_rd_adr[w_idx] == sb.dec_rs1_adr))
               ? !r_ready[w_idx] : w_haz1;
      w_haz2 = (w_rs2_chk && r_valid[w_idx] && r_rd_en[w_idx] && (r_rd_adr[w_idx] == sb.dec_rs2_adr))
               ? !r_ready[w_idx] : w_haz2;
    end
  end

  // Entry storage, pointers, occupancy and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= {DEPTH{1'b0}};
      r_rd_en   <= {DEPTH{1'b0}};
      r_is_load <= {DEPTH{1'b0}};
      r_ready   <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) r_rd_adr[i] <= 5'd0;
      r_head    <= {AW{1'b0}};
      r_tail    <= {AW{1'b0}};
      r_count   <= {CW{1'b0}};
      r_perr    <= 1'b0;
    end else begin
      if (w_issue_acc) begin
        r_valid[r_tail]   <= 1'b1;
        r_rd_en[r_tail]   <= sb.issue_rd_en && (sb.issue_rd_adr != 5'd0);
        r_rd_adr[r_tail]  <= sb.issue_rd_adr;
        r_is_load[r_tail] <= sb.issue_is_load;
        r_ready[r_tail]   <= !(sb.issue_is_load && sb.issue_rd_en);
        r_tail            <= r_tail + {{(AW-1){1'b0}}, 1'b1};
      end
      if (sb.dmem_rsp_valid && w_ld_found) begin
        r_ready[w_ld_idx] <= 1'b1;
      end
      if (w_retire_acc) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + {{(AW-1){1'b0}}, 1'b1};
      end
      r_count <= r_count + {{(CW-1){1'b0}}, w_issue_acc} - {{(CW-1){1'b0}}, w_retire_acc};
      if (w_perr_set) begin
        r_perr <= 1'b1;
      end
    end
  end

  assign sb.stall        = w_haz1 | w_haz2 | w_full;
  assign sb.full         = w_full;
  assign sb.count        = r_count;
  assign sb.load_pending = w_ld_found;
  assign sb.protocol_err = r_perr;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table plus randomized traffic against a queue-based model of the scoreboard.
module tb_hazard_scoreboard;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  hazard_scoreboard_if #(.DEPTH(DEPTH)) sbi();

  hazard_scoreboard #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .sb(sbi));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rd_en;
    bit [4:0] rd;
    bit       ld;
    bit       rdy;
  } ent_t;

  typedef struct {
    bit       iv;
    bit [4:0] rd;
    bit       ld;
    bit       rsp;
    bit       wb;
    bit       r1en;
    bit [4:0] r1;
    bit       r2en;
    bit [4:0] r2;
    bit       es;
    int       ec;
    bit       ef;
    bit       elp;
    bit       ep;
  } vec_t;

  ent_t q[$];
  bit   m_perr;
  bit   m_chk;
  int   n_err;
  int   n_chk;
  logic smp_stall, smp_full, smp_lp, smp_perr;
  logic [31:0] smp_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_haz(bit en, bit [4:0] rs);
    if (!en || rs == 5'd0) return 1'b0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].rd_en && q[i].rd == rs) return !q[i].rdy;
    return 1'b0;
  endfunction

  function automatic bit m_lp();
    foreach (q[i]) if (q[i].ld && !q[i].rdy) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall(bit r1en, bit [4:0] r1, bit r2en, bit [4:0] r2);
    return m_haz(r1en, r1) || m_haz(r2en, r2) || (q.size() == DEPTH);
  endfunction

  // Apply one cycle of inputs: check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input bit r, input bit iv, input bit en, input bit [4:0] rd, input bit ld,
                      input bit rsp, input bit wb, input bit r1en, input bit [4:0] r1,
                      input bit r2en, input bit [4:0] r2);
    bit full_now, head_rdy, found;
    ent_t e;
    rst = r;
    sbi.issue_valid = iv; sbi.issue_rd_en = en; sbi.issue_rd_adr = rd; sbi.issue_is_load = ld;
    sbi.dmem_rsp_valid = rsp; sbi.wb_valid = wb;
    sbi.dec_rs1_en = r1en; sbi.dec_rs1_adr = r1; sbi.dec_rs2_en = r2en; sbi.dec_rs2_adr = r2;
    #3;
    smp_stall = sbi.stall; smp_full = sbi.full; smp_lp = sbi.load_pending;
    smp_perr = sbi.protocol_err; smp_count = 32'(sbi.count);
    if (m_chk) begin
      chk("model_stall", {31'd0, smp_stall}, {31'd0, m_stall(r1en, r1, r2en, r2)});
      chk("model_full", {31'd0, smp_full}, {31'd0, q.size() == DEPTH});
      chk("model_count", smp_count, 32'(q.size()));
      chk("model_load_pending", {31'd0, smp_lp}, {31'd0, m_lp()});
      chk("model_protocol_err", {31'd0, smp_perr}, {31'd0, m_perr});
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_perr = 1'b0;
    end else begin
      full_now = (q.size() == DEPTH);
      head_rdy = (q.size() > 0) ? q[0].rdy : 1'b0;
      if (rsp) begin
        found = 1'b0;
        foreach (q[i]) if (!found && q[i].ld && !q[i].rdy) begin q[i].rdy = 1'b1; found = 1'b1; end
        if (!found) m_perr = 1'b1;
      end
      if (wb) begin
        if (q.size() == 0) m_perr = 1'b1;
        else begin
          if (!head_rdy) m_perr = 1'b1;
          void'(q.pop_front());
        end
      end
      if (iv) begin
        if (full_now) m_perr = 1'b1;
        else begin
          e.rd_en = en && (rd != 5'd0); e.rd = rd; e.ld = ld; e.rdy = !(ld && en);
          q.push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  function automatic vec_t v(bit iv, bit [4:0] rd, bit ld, bit rsp, bit wb, bit r1en, bit [4:0] r1,
                             bit r2en, bit [4:0] r2, bit es, int ec, bit ef, bit elp, bit ep);
    vec_t t;
    t.iv = iv; t.rd = rd; t.ld = ld; t.rsp = rsp; t.wb = wb;
    t.r1en = r1en; t.r1 = r1; t.r2en = r2en; t.r2 = r2;
    t.es = es; t.ec = ec; t.ef = ef; t.elp = elp; t.ep = ep;
    return t;
  endfunction

  vec_t tbl[32];

  initial begin
    bit r1en, r2en, iv, en, ld, rsp, wb;
    bit [4:0] r1, r2, rd;
    n_err = 0; n_chk = 0; m_chk = 1'b0; m_perr = 1'b0;
    #1;
    do_reset();
    do_reset();
    m_chk = 1'b1;

    //       iv rd ld rsp wb r1en r1 r2en r2  st cnt fu lp pe
    tbl[0]  = v(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 0, 0, 0, 1, 5, 1, 1,  1, 1, 0, 1, 0);
    tbl[2]  = v(0, 0, 0, 1, 0, 1, 5, 0, 0,  1, 1, 0, 1, 0);
    tbl[3]  = v(0, 0, 0, 0, 0, 1, 5, 0, 0,  0, 1, 0, 0, 0);
    tbl[4]  = v(0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    tbl[5]  = v(1, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[6]  = v(1, 7, 0, 0, 0, 0, 0, 1, 7,  1, 1, 0, 1, 0);
    tbl[7]  = v(0, 0, 0, 0, 0, 1, 7, 0, 0,  0, 2, 0, 1, 0);
    tbl[8]  = v(0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 2, 0, 1, 0);
    tbl[9]  = v(0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 2, 0, 0, 0);
    tbl[10] = v(0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    tbl[11] = v(1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[12] = v(1, 7, 1, 0, 0, 1, 7, 0, 0,  0, 1, 0, 0, 0);
    tbl[13] = v(0, 0, 0, 0, 0, 1, 7, 0, 0,  1, 2, 0, 1, 0);
    tbl[14] = v(0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 2, 0, 1, 0);
    tbl[15] = v(0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 2, 0, 0, 0);
    tbl[16] = v(0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    tbl[17] = v(1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[18] = v(0, 0, 0, 0, 0, 1, 0, 0, 5,  0, 1, 0, 1, 0);
    tbl[19] = v(0, 0, 0, 0, 0, 0, 5, 1, 0,  0, 1, 0, 1, 0);
    tbl[20] = v(0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0);
    tbl[21] = v(0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    tbl[22] = v(1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[23] = v(1, 2, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    tbl[24] = v(1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0);
    tbl[25] = v(1, 4, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0, 0);
    tbl[26] = v(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4, 1, 0, 0);
    tbl[27] = v(1, 9, 0, 0, 1, 0, 0, 0, 0,  1, 4, 1, 0, 0);
    tbl[28] = v(0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 3, 0, 0, 1);
    tbl[29] = v(0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 2, 0, 0, 1);
    tbl[30] = v(0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1);
    tbl[31] = v(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].iv, tbl[i].iv, tbl[i].rd, tbl[i].ld, tbl[i].rsp, tbl[i].wb,
           tbl[i].r1en, tbl[i].r1, tbl[i].r2en, tbl[i].r2);
      chk($sformatf("tbl%0d_stall", i), {31'd0, smp_stall}, {31'd0, tbl[i].es});
      chk($sformatf("tbl%0d_count", i), smp_count, tbl[i].ec);
      chk($sformatf("tbl%0d_full", i), {31'd0, smp_full}, {31'd0, tbl[i].ef});
      chk($sformatf("tbl%0d_load_pending", i), {31'd0, smp_lp}, {31'd0, tbl[i].elp});
      chk($sformatf("tbl%0d_perr", i), {31'd0, smp_perr}, {31'd0, tbl[i].ep});
    end

    // Retire on empty.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    idle();
    chk("wb_empty_perr", {31'd0, smp_perr}, 32'd1);
    chk("wb_empty_count", smp_count, 32'd0);

    // Load response with nothing outstanding.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    idle();
    chk("rsp_none_perr", {31'd0, smp_perr}, 32'd1);

    // Retiring a load whose data has not returned still pops it.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    idle();
    chk("wb_notready_perr", {31'd0, smp_perr}, 32'd1);
    chk("wb_notready_count", smp_count, 32'd0);

    do_reset();
    for (int c = 0; c < 2000; c++) begin
      r1en = ($urandom_range(0, 3) != 0); r1 = 5'($urandom_range(0, 7));
      r2en = ($urandom_range(0, 3) != 0); r2 = 5'($urandom_range(0, 7));
      en = ($urandom_range(0, 3) != 0); rd = 5'($urandom_range(0, 7)); ld = $urandom_range(0, 1) == 1;
      if (c % 250 == 249) begin
        step(1'b1, 1'($urandom), en, rd, ld, 1'($urandom), 1'($urandom), r1en, r1, r2en, r2);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, r1en, r1, r2en, r2);
        chk("rst_count", smp_count, 32'd0);
        chk("rst_full", {31'd0, smp_full}, 32'd0);
        chk("rst_stall", {31'd0, smp_stall}, 32'd0);
        chk("rst_perr", {31'd0, smp_perr}, 32'd0);
      end else begin
        iv  = ($urandom_range(0, 2) != 0) &&
              (!m_stall(r1en, r1, r2en, r2) || $urandom_range(0, 40) == 0);
        rsp = m_lp() ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
        wb  = (q.size() > 0 && q[0].rdy) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 60) == 0);
        step(1'b0, iv, en, rd, ld, rsp, wb, r1en, r1, r2en, r2);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
